// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the datapath controller and muldiv_unit.
// The controller drives start/op/A/B and stalls on busy before reading hi/lo.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             dbz;

    modport master (output start, op, A, B, input busy, done, hi, lo, dbz);
    modport slave  (input start, op, A, B, output busy, done, hi, lo, dbz);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO registers, WIDTH+1 cycles per op.
// Operates on magnitudes and fixes signs in a final cycle; MTHI/MTLO are single-cycle writes.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rstn,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t             r_state, w_next;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opb;
    logic               r_is_div, r_neg_q, r_neg_r, r_bzero;
    logic               r_busy, r_done, r_dbz;
    logic [WIDTH-1:0]   r_hi, r_lo;

    logic               w_a_neg, w_b_neg, w_last;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag;
    logic [WIDTH:0]     w_mul_sum, w_rem_sh, w_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo, w_rem;

    // op[0] selects the signed variant, op[1] selects divide, op[2] the MTxx/NOP group
    assign w_a_neg = bus.op[0] & bus.A[WIDTH-1];
    assign w_b_neg = bus.op[0] & bus.B[WIDTH-1];
    assign w_a_mag = w_a_neg ? -bus.A : bus.A;
    assign w_b_mag = w_b_neg ? -bus.B : bus.B;
    assign w_last  = (r_cnt == CW'(1));

    // Low half of r_acc holds the multiplier (shifted out) or dividend/quotient (shifted in);
    // high half holds the partial product or the running remainder.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    assign w_rem_sh  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_opb};

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (bus.start && !bus.op[2]) w_next = bus.op[1] ? DIV : MUL;
            MUL:  if (w_last) w_next = FIX;
            DIV:  if (w_last) w_next = FIX;
            FIX:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_bzero  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        if (!bus.op[2]) begin
                            r_acc    <= {{WIDTH{1'b0}}, w_a_mag};
                            r_opb    <= w_b_mag;
                            r_cnt    <= CW'(WIDTH);
                            r_busy   <= 1'b1;
                            r_is_div <= bus.op[1];
                            r_neg_q  <= w_a_neg ^ w_b_neg;
                            r_neg_r  <= w_a_neg;
                            r_bzero  <= bus.op[1] && (bus.B == '0);
                        end else if (bus.op[1:0] == 2'd0) begin
                            r_hi <= bus.A;
                        end else if (bus.op[1:0] == 2'd1) begin
                            r_lo <= bus.A;
                        end
                    end
                end
                MUL: begin
                    r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
                    r_cnt <= r_cnt - CW'(1);
                end
                DIV: begin
                    // Restoring step: keep the shifted remainder when the trial subtract goes negative
                    if (w_diff[WIDTH])
                        r_acc <= {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
                    else
                        r_acc <= {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
                    r_cnt <= r_cnt - CW'(1);
                end
                FIX: begin
                    if (r_is_div) begin
                        r_lo <= r_bzero ? {WIDTH{1'b1}} : w_quo;
                        r_hi <= w_rem;
                    end else begin
                        {r_hi, r_lo} <= w_prod;
                    end
                    r_dbz  <= r_bzero;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
    assign bus.dbz  = r_dbz;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed cases plus random ops on WIDTH=32 and WIDTH=8 instances,
// checked against a plain-arithmetic reference model.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rstn;
    int   n_checks = 0;
    int   n_err = 0;

    muldiv_unit_if #(.WIDTH(32)) b32 ();
    muldiv_unit_if #(.WIDTH(8))  b8 ();

    muldiv_unit #(.WIDTH(32)) u32 (.clk(clk), .rstn(rstn), .bus(b32));
    muldiv_unit #(.WIDTH(8))  u8  (.clk(clk), .rstn(rstn), .bus(b8));

    always #5 clk = ~clk;

    // MULT/MULTU/DIV/DIVU results from the arithmetic definition on 64-bit integers
    function automatic void model(input int w, input logic [2:0] op, input longint unsigned a,
                                  input longint unsigned b, output longint unsigned hi,
                                  output longint unsigned lo, output bit dbz);
        longint unsigned mask;
        longint sa, sb, p, q, r;
        mask = (64'd1 << w) - 64'd1;
        sa = longint'(a);
        sb = longint'(b);
        if (op[0]) begin
            if (a[w-1]) sa = sa - longint'(64'd1 << w);
            if (b[w-1]) sb = sb - longint'(64'd1 << w);
        end
        dbz = 1'b0;
        if (!op[1]) begin
            p  = sa * sb;
            lo = longint'(p) & mask;
            hi = (p >> w) & mask;
        end else if (b == 0) begin
            lo  = mask;
            hi  = a;
            dbz = 1'b1;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            lo = q & mask;
            hi = r & mask;
        end
    endfunction

    function automatic logic [31:0] rnd_opnd(input int w);
        logic [31:0] v, m;
        m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        case ($urandom_range(0, 7))
            0: v = 32'd0;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'd1 << (w - 1);
            3: v = 32'd1;
            default: v = $urandom;
        endcase
        return v & m;
    endfunction

    // Caller is #1 after a rising edge; the next edge is the start edge. Returns at the done sample
    // (or after the cycle budget) so the next request may be issued back-to-back.
    task automatic run_op(input bit w8, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int bcnt, output bit ok);
        logic bsy, dn;
        if (w8) begin b8.start = 1'b1; b8.op = op; b8.A = a[7:0]; b8.B = b[7:0]; end
        else    begin b32.start = 1'b1; b32.op = op; b32.A = a; b32.B = b; end
        @(posedge clk); #1;
        if (w8) begin b8.start = 1'b0; b8.A = 8'($urandom); b8.B = 8'($urandom); end
        else    begin b32.start = 1'b0; b32.A = $urandom; b32.B = $urandom; end
        lat = 0; bcnt = 0; ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            dn  = w8 ? b8.done : b32.done;
            bsy = w8 ? b8.busy : b32.busy;
            if (dn) begin ok = 1'b1; break; end
            if (bsy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        n_checks++; if (b32.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b exp 0", b32.busy); end
        n_checks++; if (b32.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b exp 0", b32.done); end
        n_checks++; if (b32.dbz !== 1'b0) begin n_err++; $display("FAIL reset_dbz: got %b exp 0", b32.dbz); end
        n_checks++; if (b32.hi !== 32'd0) begin n_err++; $display("FAIL reset_hi: got %h exp 0", b32.hi); end
        n_checks++; if (b32.lo !== 32'd0) begin n_err++; $display("FAIL reset_lo: got %h exp 0", b32.lo); end
        n_checks++; if ({b8.hi, b8.lo, b8.busy} !== 17'd0) begin n_err++; $display("FAIL reset_w8: got %h exp 0", {b8.hi, b8.lo, b8.busy}); end
    endtask

    task automatic test_multu_max();
        int lat, bc; bit ok;
        run_op(1'b0, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc, ok);
        n_checks++; if (!ok || lat != 33) begin n_err++; $display("FAIL multu_latency: got %0d (done=%b) exp 33", lat, ok); end
        n_checks++; if (bc != 33) begin n_err++; $display("FAIL multu_busy_cycles: got %0d exp 33", bc); end
        n_checks++; if (b32.busy !== 1'b0) begin n_err++; $display("FAIL multu_busy_at_done: got %b exp 0", b32.busy); end
        n_checks++; if (b32.hi !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL multu_hi: got %h exp fffffffe", b32.hi); end
        n_checks++; if (b32.lo !== 32'h0000_0001) begin n_err++; $display("FAIL multu_lo: got %h exp 00000001", b32.lo); end
        @(posedge clk); #1;
        n_checks++; if (b32.done !== 1'b0) begin n_err++; $display("FAIL done_one_cycle: got %b exp 0", b32.done); end
    endtask

    task automatic test_mult_signed();
        int lat, bc; bit ok;
        run_op(1'b0, 3'd1, 32'hFFFF_FFFD, 32'd5, lat, bc, ok);
        n_checks++; if (!ok) begin n_err++; $display("FAIL mult_done: got none exp pulse"); end
        n_checks++; if ({b32.hi, b32.lo} !== 64'hFFFF_FFFF_FFFF_FFF1) begin n_err++; $display("FAIL mult_neg: got %h_%h exp ffffffff_fffffff1", b32.hi, b32.lo); end
        n_checks++; if (b32.dbz !== 1'b0) begin n_err++; $display("FAIL mult_dbz: got %b exp 0", b32.dbz); end
    endtask

    task automatic test_div_signed();
        int lat, bc; bit ok;
        run_op(1'b0, 3'd3, 32'hFFFF_FFF9, 32'd2, lat, bc, ok);
        n_checks++; if (!ok || lat != 33) begin n_err++; $display("FAIL div_latency: got %0d exp 33", lat); end
        n_checks++; if ({b32.hi, b32.lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_err++; $display("FAIL div_neg: got %h_%h exp ffffffff_fffffffd", b32.hi, b32.lo); end
        run_op(1'b0, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc, ok);
        n_checks++; if (!ok || {b32.hi, b32.lo} !== 64'h0000_0000_8000_0000) begin n_err++; $display("FAIL div_overflow: got %h_%h exp 00000000_80000000", b32.hi, b32.lo); end
        n_checks++; if (b32.dbz !== 1'b0) begin n_err++; $display("FAIL div_overflow_dbz: got %b exp 0", b32.dbz); end
    endtask

    task automatic test_div_zero();
        int lat, bc; bit ok;
        run_op(1'b0, 3'd2, 32'h1234, 32'd0, lat, bc, ok);
        n_checks++; if (!ok || lat != 33) begin n_err++; $display("FAIL dbz_latency: got %0d exp 33", lat); end
        n_checks++; if ({b32.hi, b32.lo} !== 64'h0000_1234_FFFF_FFFF) begin n_err++; $display("FAIL dbz_result: got %h_%h exp 00001234_ffffffff", b32.hi, b32.lo); end
        n_checks++; if (b32.dbz !== 1'b1) begin n_err++; $display("FAIL dbz_flag: got %b exp 1", b32.dbz); end
        @(posedge clk); #1;
        n_checks++; if (b32.dbz !== 1'b1) begin n_err++; $display("FAIL dbz_hold: got %b exp 1", b32.dbz); end
        run_op(1'b0, 3'd0, 32'd2, 32'd3, lat, bc, ok);
        n_checks++; if (!ok || b32.lo !== 32'd6 || b32.hi !== 32'd0) begin n_err++; $display("FAIL dbz_then_mul: got %h_%h exp 00000000_00000006", b32.hi, b32.lo); end
        n_checks++; if (b32.dbz !== 1'b0) begin n_err++; $display("FAIL dbz_cleared: got %b exp 0", b32.dbz); end
    endtask

    task automatic test_mthi_mtlo();
        logic [31:0] v1, v2;
        v1 = $urandom; v2 = $urandom;
        b32.start = 1'b1; b32.op = 3'd4; b32.A = v1;
        @(posedge clk); #1;
        n_checks++; if (b32.hi !== v1) begin n_err++; $display("FAIL mthi: got %h exp %h", b32.hi, v1); end
        n_checks++; if (b32.busy !== 1'b0 || b32.done !== 1'b0) begin n_err++; $display("FAIL mthi_handshake: got busy=%b done=%b exp 0 0", b32.busy, b32.done); end
        b32.op = 3'd5; b32.A = v2;
        @(posedge clk); #1;
        n_checks++; if (b32.lo !== v2 || b32.hi !== v1) begin n_err++; $display("FAIL mtlo: got %h_%h exp %h_%h", b32.hi, b32.lo, v1, v2); end
        b32.op = 3'd6; b32.A = ~v1;
        @(posedge clk); #1;
        b32.op = 3'd7;
        @(posedge clk); #1;
        b32.start = 1'b0;
        n_checks++; if (b32.lo !== v2 || b32.hi !== v1 || b32.busy !== 1'b0) begin n_err++; $display("FAIL nop: got %h_%h busy=%b exp %h_%h busy=0", b32.hi, b32.lo, b32.busy, v1, v2); end
    endtask

    task automatic test_mthi_while_busy();
        logic [31:0] prev_hi;
        bit ok;
        prev_hi = b32.hi;
        b32.start = 1'b1; b32.op = 3'd2; b32.A = 32'd100; b32.B = 32'd7;
        @(posedge clk); #1;
        b32.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        b32.start = 1'b1; b32.op = 3'd4; b32.A = 32'hAA;
        @(posedge clk); #1;
        b32.start = 1'b0; b32.A = $urandom; b32.B = $urandom;
        n_checks++; if (b32.hi !== prev_hi || b32.busy !== 1'b1) begin n_err++; $display("FAIL hi_held_busy: got %h busy=%b exp %h busy=1", b32.hi, b32.busy, prev_hi); end
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (b32.done) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        n_checks++; if (!ok || b32.hi !== 32'd2 || b32.lo !== 32'd14) begin n_err++; $display("FAIL mthi_ignored: got %h_%h done=%b exp 00000002_0000000e", b32.hi, b32.lo, ok); end
    endtask

    task automatic test_reset_abort();
        int ndone;
        b32.start = 1'b1; b32.op = 3'd2; b32.A = 32'd100; b32.B = 32'd7;
        @(posedge clk); #1;
        b32.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        n_checks++; if ({b32.hi, b32.lo} !== 64'd0) begin n_err++; $display("FAIL abort_hilo: got %h_%h exp 0", b32.hi, b32.lo); end
        n_checks++; if ({b32.busy, b32.done, b32.dbz} !== 3'b000) begin n_err++; $display("FAIL abort_flags: got %b exp 000", {b32.busy, b32.done, b32.dbz}); end
        @(posedge clk); #1;
        rstn = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (b32.done || b32.busy) ndone++;
            @(posedge clk); #1;
        end
        n_checks++; if (ndone != 0) begin n_err++; $display("FAIL abort_no_done: got %0d active cycles exp 0", ndone); end
    endtask

    task automatic test_back_to_back();
        int lat, bc; bit ok;
        run_op(1'b1, 3'd1, 32'h80, 32'h80, lat, bc, ok);
        n_checks++; if (!ok || lat != 9) begin n_err++; $display("FAIL w8_latency: got %0d exp 9", lat); end
        n_checks++; if ({b8.hi, b8.lo} !== 16'h4000) begin n_err++; $display("FAIL w8_mult: got %h_%h exp 40_00", b8.hi, b8.lo); end
        run_op(1'b1, 3'd2, 32'd200, 32'd7, lat, bc, ok);
        n_checks++; if (!ok || lat != 9 || bc != 9) begin n_err++; $display("FAIL b2b_latency: got lat=%0d busy=%0d exp 9 9", lat, bc); end
        n_checks++; if ({b8.hi, b8.lo} !== {8'd4, 8'd28}) begin n_err++; $display("FAIL b2b_divu: got %h_%h exp 04_1c", b8.hi, b8.lo); end
        b8.start = 1'b1; b8.op = 3'd5; b8.A = 8'h5A;
        @(posedge clk); #1;
        b8.start = 1'b0;
        n_checks++; if ({b8.hi, b8.lo, b8.done} !== {8'd4, 8'h5A, 1'b0}) begin n_err++; $display("FAIL mtlo_in_done: got %h_%h done=%b exp 04_5a done=0", b8.hi, b8.lo, b8.done); end
    endtask

    task automatic test_random();
        int lat, bc, w; bit ok, ed, w8;
        logic [2:0] op; logic [31:0] a, b, ghi, glo; bit gdbz;
        longint unsigned eh, el;
        for (int i = 0; i < 40; i++) begin
            w8 = i[0];
            w  = w8 ? 8 : 32;
            op = 3'($urandom_range(0, 3));
            a  = rnd_opnd(w);
            b  = rnd_opnd(w);
            model(w, op, longint'(a), longint'(b), eh, el, ed);
            run_op(w8, op, a, b, lat, bc, ok);
            ghi  = w8 ? {24'd0, b8.hi} : b32.hi;
            glo  = w8 ? {24'd0, b8.lo} : b32.lo;
            gdbz = w8 ? b8.dbz : b32.dbz;
            n_checks++; if (!ok || lat != w + 1) begin n_err++; $display("FAIL rnd_latency w=%0d op=%0d: got %0d exp %0d", w, op, lat, w + 1); end
            n_checks++; if (ghi !== eh[31:0]) begin n_err++; $display("FAIL rnd_hi w=%0d op=%0d a=%h b=%h: got %h exp %h", w, op, a, b, ghi, eh[31:0]); end
            n_checks++; if (glo !== el[31:0]) begin n_err++; $display("FAIL rnd_lo w=%0d op=%0d a=%h b=%h: got %h exp %h", w, op, a, b, glo, el[31:0]); end
            n_checks++; if (gdbz !== ed) begin n_err++; $display("FAIL rnd_dbz w=%0d op=%0d: got %b exp %b", w, op, gdbz, ed); end
        end
    endtask

    initial begin
        rstn = 1'b0;
        b32.start = 1'b0; b32.op = 3'd0; b32.A = '0; b32.B = '0;
        b8.start  = 1'b0; b8.op  = 3'd0; b8.A  = '0; b8.B  = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rstn = 1'b1;
        @(posedge clk); #1;
        test_multu_max();
        test_mult_signed();
        test_div_signed();
        test_div_zero();
        test_mthi_mtlo();
        test_mthi_while_busy();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit with HI/LO result registers, WIDTH bits wide. It sits beside the single-cycle ALU in the datapath and executes MULT/MULTU/DIV/DIVU in WIDTH+1 cycles, plus single-cycle MTHI/MTLO writes. It uses a start/busy/done handshake so the controller can stall on MFHI/MFLO while an operation is in flight.

## Interface
- WIDTH, 32, operand and HI/LO width; any value ≥ 4.
- clk  in  1  clock; all state changes on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- start  in  1  operation request; sampled only when busy=0.
- op  in  3  operation code: 0 MULTU, 1 MULT, 2 DIVU, 3 DIV, 4 MTHI, 5 MTLO, 6/7 NOP.
- A  in  WIDTH  first operand: multiplicand or dividend; source for MTHI/MTLO.
- B  in  WIDTH  second operand: multiplier or divisor.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse: HI/LO updated for a mul/div.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- dbz  out  1  last completed divide had divisor zero.

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE with start=1 and op 0–3:
  - Latch the operand magnitudes. For signed ops, take the absolute value in two's complement.
  - Record the result signs.
  - Load the iteration counter with WIDTH and go to MUL or DIV.
- IDLE with start=1 and op 4/5: hi (or lo) <= A at the next edge. No busy, no done. Op 6/7 does nothing.
- MUL: radix-2 shift-add, one multiplier bit per cycle, 2·WIDTH-bit accumulator. After WIDTH cycles, go to FIX.
- DIV: restoring division, one quotient bit per cycle. After WIDTH cycles, go to FIX.
- FIX, one cycle:
  - Apply the sign correction: product negated if the signs differ; quotient negated if the signs differ; remainder takes the dividend's sign.
  - Write hi/lo, assert done, clear busy, return to IDLE.
- Multiply result: {hi,lo} = full 2·WIDTH-bit product, signed or unsigned per op.
- Divide result: lo = quotient truncated toward zero; hi = remainder.
- Divisor zero (DIV/DIVU):
  - Takes the normal latency.
  - lo = all ones, hi = A unchanged, dbz = 1.
- Signed overflow (MIN / −1): lo = MIN, hi = 0, dbz = 0. This falls out of the magnitude datapath, with no special case.
- dbz is updated on every done: 1 only for a divide by zero; 0 after any mul or a normal div. It holds between completions.
- start while busy=1 is ignored entirely, including op 4/5. Operand changes while busy have no effect.
- hi/lo keep their old values throughout a mul/div until FIX.

## Timing
- Reset (asynchronous, rstn=0): state IDLE; busy=0, done=0, dbz=0, hi=0, lo=0.
- Reset during an operation aborts it; no done is issued.
- Mul/div started at edge 0:
  - busy=1 after edge 0 through edge WIDTH.
  - Edges 1..WIDTH are iterations.
  - At edge WIDTH+1, FIX writes hi/lo. done=1 and busy=0 for the cycle after edge WIDTH+1.
  - Latency: WIDTH+1 cycles from the start edge to valid hi/lo.
- done cycle: the state is IDLE, so a new start in that cycle is accepted (back-to-back, no bubble). done deasserts the following cycle unless that op also completes.
- MTHI/MTLO: result visible after one edge. They may be issued in the done cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- MULTU, WIDTH=32, A=B=0xFFFFFFFF -> done exactly 33 cycles after the start edge; hi=0xFFFFFFFE, lo=0x00000001; busy high for 33 cycles.
- MULT A=−3 (0xFFFFFFFD), B=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1, dbz=0.
- DIV A=−7, B=2 -> lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). Then DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU A=0x1234, B=0 -> lo=0xFFFFFFFF, hi=0x00001234, dbz=1. A following MULTU 2×3 -> dbz=0, lo=6.
- Start DIVU 100/7, pulse start with MTHI A=0xAA at cycle 5, then assert rstn=0 at cycle 10 in a second run:
  - First run: MTHI is ignored; hi=2, lo=14.
  - Second run: outputs go to 0 immediately; no done pulse.
- WIDTH=8 instance:
  - MULT 0x80×0x80 -> hi=0x40, lo=0x00, done 9 cycles after start.
  - Back-to-back start in the done cycle is accepted.
